// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU control bundle
// for the boot loader; the host/bench side uses master, the loader uses slave.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data, reload,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    input  in_valid, in_data, reload,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a big-endian image (16-bit word count, then 32-bit words) from a byte
// stream into instruction memory, holding the CPU in reset until it is complete.
module imem_boot_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.slave bus
);
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_RUN, S_ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_lenHi;
  logic [15:0]       r_len;
  logic [23:0]       r_word;
  logic [1:0]        r_byteCnt;
  logic [15:0]       r_wordCnt;
  logic [TO_W-1:0]   r_toCnt;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memWdata;
  logic              r_cpuRst;

  logic              w_inReady;
  logic              w_accept;
  logic [15:0]       w_lenFull;
  logic              w_lenTooBig;
  logic              w_dataDone;
  logic              w_timeout;
  logic              w_wordByte;
  logic              w_lastByte;

  assign w_inReady   = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
  assign w_accept    = bus.in_valid && w_inReady;
  assign w_lenFull   = {r_lenHi, bus.in_data};
  assign w_lenTooBig = {1'b0, w_lenFull} > (17'd1 << ADDR_W);
  // All words received: the cycle carrying the final mem_we, bytes here are ignored.
  assign w_dataDone  = (r_wordCnt == r_len);
  assign w_timeout   = (r_toCnt == TO_W'(TIMEOUT_CYC - 1)) && !w_accept;
  assign w_wordByte  = w_accept && (r_state == S_DATA) && !w_dataDone && !bus.reload;
  assign w_lastByte  = w_wordByte && (r_byteCnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LEN0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.reload) begin
      w_next = S_LEN0;
    end else begin
      case (r_state)
        S_LEN0: if (w_accept) w_next = S_LEN1;
        S_LEN1: begin
          if (w_accept) begin
            if (w_lenFull == 16'd0) w_next = S_RUN;
            else if (w_lenTooBig)   w_next = S_ERR;
            else                    w_next = S_DATA;
          end else if (w_timeout) begin
            w_next = S_ERR;
          end
        end
        S_DATA: begin
          if (w_dataDone)     w_next = S_RUN;
          else if (w_timeout) w_next = S_ERR;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lenHi    <= '0;
      r_len      <= '0;
      r_word     <= '0;
      r_byteCnt  <= '0;
      r_wordCnt  <= '0;
      r_toCnt    <= '0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_cpuRst   <= 1'b1;
    end else begin
      r_memWe  <= w_lastByte;
      r_cpuRst <= (w_next != S_RUN);
      if (bus.reload) begin
        r_byteCnt <= '0;
        r_wordCnt <= '0;
        r_toCnt   <= '0;
      end else begin
        if ((r_state == S_LEN0) && w_accept) r_lenHi <= bus.in_data;
        if ((r_state == S_LEN1) && w_accept) r_len   <= w_lenFull;
        if (w_wordByte) begin
          r_word    <= {r_word[15:0], bus.in_data};
          r_byteCnt <= r_byteCnt + 2'd1;
        end
        if (w_lastByte) begin
          r_memAddr  <= r_wordCnt[ADDR_W-1:0];
          r_memWdata <= {r_word, bus.in_data};
          r_wordCnt  <= r_wordCnt + 16'd1;
        end
        if (w_accept || (w_next != r_state))
          r_toCnt <= '0;
        else if ((r_state == S_LEN1) || (r_state == S_DATA))
          r_toCnt <= r_toCnt + TO_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.mem_we    = r_memWe;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.cpu_rst   = r_cpuRst;
  assign bus.busy      = (r_state == S_LEN1) || (r_state == S_DATA);
  assign bus.done      = (r_state == S_RUN);
  assign bus.err       = (r_state == S_ERR);
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal loads, empty and oversized images,
// inter-byte timeout, reload behaviour and asynchronous reset mid-load.
module tb_imem_boot_loader;
  logic clk;
  logic rst;
  int   testsRun  = 0;
  int   failCount = 0;
  logic [39:0] weLog[$];

  imem_boot_loader_if #(.ADDR_W(8)) bus ();

  imem_boot_loader #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write pulse lasts one full cycle, so one sample per falling edge logs it once.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) weLog.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic checkOutput(input string tag, input logic [40:0] observed, input logic [40:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Status packed as {cpu_rst, done, err, busy, in_ready}.
  task automatic checkStatus(input string tag, input logic [4:0] expected);
    checkOutput(tag, {36'd0, bus.cpu_rst, bus.done, bus.err, bus.busy, bus.in_ready}, {36'd0, expected});
  endtask

  task automatic checkMem(input string tag, input logic we, input logic [7:0] addr, input logic [31:0] data);
    checkOutput(tag, {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {we, addr, data});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulseReload();
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.reload   = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkStatus("reset_status", 5'b10001);
    checkMem("reset_mem", 1'b0, 8'h00, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two-word image, back-to-back
    applyStimulus(8'h00);
    checkStatus("len1_status", 5'b10011);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    checkMem("word0_write", 1'b1, 8'h00, 32'h12345678);
    checkStatus("word0_status", 5'b10011);
    applyStimulus(8'h9A);
    applyStimulus(8'hBC);
    applyStimulus(8'hDE);
    applyStimulus(8'hF0);
    checkMem("word1_write", 1'b1, 8'h01, 32'h9ABCDEF0);
    checkStatus("last_we_status", 5'b10011);
    tick(1);
    checkStatus("run_status", 5'b01000);
    checkMem("run_mem", 1'b0, 8'h01, 32'h9ABCDEF0);
    applyStimulus(8'hFF);
    tick(2);
    checkOutput("two_word_count", 41'(weLog.size()), 41'd2);
    checkOutput("two_word_log0", {1'b0, weLog[0]}, {1'b0, 8'h00, 32'h12345678});
    checkOutput("two_word_log1", {1'b0, weLog[1]}, {1'b0, 8'h01, 32'h9ABCDEF0});
    checkStatus("run_ignores_bytes", 5'b01000);

    // Empty image
    pulseReload();
    checkStatus("reload_from_run", 5'b10001);
    weLog.delete();
    applyStimulus(8'h00);
    checkStatus("empty_len1", 5'b10011);
    applyStimulus(8'h00);
    checkStatus("empty_run", 5'b01000);
    tick(2);
    checkOutput("empty_no_we", 41'(weLog.size()), 41'd0);

    // Oversized image (257 words)
    pulseReload();
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    checkStatus("oversize_err", 5'b10100);
    tick(2);
    checkStatus("oversize_hold", 5'b10100);
    checkOutput("oversize_no_we", 41'(weLog.size()), 41'd0);

    // Timeout: 16 idle cycles after a data byte
    pulseReload();
    checkStatus("err_cleared", 5'b10001);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    tick(15);
    checkStatus("idle15_no_err", 5'b10011);
    tick(1);
    checkStatus("idle16_err", 5'b10100);
    checkOutput("timeout_no_we", 41'(weLog.size()), 41'd0);

    // Byte arriving on the last allowed idle cycle wins
    pulseReload();
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    tick(15);
    applyStimulus(8'hBB);
    checkStatus("late_byte_no_err", 5'b10011);
    applyStimulus(8'hCC);
    applyStimulus(8'hDD);
    checkMem("late_byte_write", 1'b1, 8'h00, 32'hAABBCCDD);
    tick(1);
    checkStatus("late_byte_run", 5'b01000);

    // Mid-image reload, then a full one-word image
    pulseReload();
    weLog.delete();
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    checkMem("abort_write", 1'b1, 8'h00, 32'h01020304);
    applyStimulus(8'h05);
    pulseReload();
    checkStatus("abort_reload", 5'b10001);
    checkMem("abort_addr_kept", 1'b0, 8'h00, 32'h01020304);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    checkMem("reload_write", 1'b1, 8'h00, 32'h11223344);
    tick(1);
    checkStatus("reload_run", 5'b01000);
    checkOutput("reload_count", 41'(weLog.size()), 41'd2);
    checkOutput("reload_log1", {1'b0, weLog[1]}, {1'b0, 8'h00, 32'h11223344});

    // Reload coinciding with the 4th byte of a word suppresses the write
    pulseReload();
    weLog.delete();
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h88;
    bus.reload   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.reload   = 1'b0;
    checkStatus("reload_4th_status", 5'b10001);
    tick(2);
    checkOutput("reload_4th_no_we", 41'(weLog.size()), 41'd0);

    // Asynchronous reset while a write pulse is high
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    applyStimulus(8'hB0);
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    applyStimulus(8'hB3);
    applyStimulus(8'hB4);
    applyStimulus(8'hB5);
    applyStimulus(8'hB6);
    applyStimulus(8'hB7);
    checkMem("pre_rst_write", 1'b1, 8'h01, 32'hB4B5B6B7);
    #2 rst = 1'b1;
    #1;
    checkMem("async_rst_mem", 1'b0, 8'h00, 32'h0);
    checkStatus("async_rst_status", 5'b10001);
    @(posedge clk);
    #1 rst = 1'b0;
    weLog.delete();
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hCA);
    applyStimulus(8'hFE);
    applyStimulus(8'hBA);
    applyStimulus(8'hBE);
    checkMem("post_rst_write", 1'b1, 8'h00, 32'hCAFEBABE);
    tick(1);
    checkStatus("post_rst_run", 5'b01000);
    checkOutput("post_rst_count", 41'(weLog.size()), 41'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the pipelined CPU's fetch stage; loads a program image into instruction memory from a byte stream (UART/host link).
- Holds the CPU in reset until the whole image has been written.
- Image format: 16-bit big-endian word count, then that many 32-bit words, each big-endian.
- Drives the instruction-memory write port and the CPU reset line.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.
- TIMEOUT_CYC, 1000, maximum idle cycles allowed between bytes once a load has started.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle pulse; abort or finish and restart the load sequence.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  instruction-memory word address.
- mem_wdata  out  32  instruction-memory write data.
- cpu_rst  out  1  reset to the CPU; active-high, registered.
- busy  out  1  load in progress.
- done  out  1  image loaded; CPU running.
- err  out  1  load failed.

Behaviour:
- Clocking and reset: clk; rst asynchronous, active-high.
- Reset values: state=S_LEN0, cpu_rst=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. Word counter, byte counter and timeout counter all 0.
- Handshake: a byte is accepted in any cycle where in_valid and in_ready are both 1.
- in_ready is 1 in S_LEN0, S_LEN1 and S_DATA, and 0 in S_RUN and S_ERR.
- S_LEN0: accepted byte -> len[15:8]; go to S_LEN1. No timeout in this state.
- S_LEN1: accepted byte -> len[7:0], then the next state is decided:
  - len==0 -> S_RUN.
  - len > 2**ADDR_W -> S_ERR.
  - otherwise -> S_DATA.
- S_DATA: bytes shift into the word register, first byte into [31:24], last into [7:0]. A 2-bit byte counter wraps 3->0.
- On the 4th byte of a word, the cycle after that handshake:
  - mem_we=1 for exactly 1 cycle;
  - mem_addr = word index (0-based);
  - mem_wdata = assembled word.
- The next word's first byte may be accepted in the same cycle mem_we is high. No bubble; in_ready stays 1.
- Last-word transition: when the last word's mem_we cycle occurs, the state moves to S_RUN on the following edge.
- S_RUN: cpu_rst=0, done=1. cpu_rst therefore falls exactly one cycle after the last mem_we pulse; for len==0 it falls one cycle after the LEN1 handshake.
- S_ERR: err=1, cpu_rst=1, mem_we=0.
- busy = 1 in S_LEN1 and S_DATA only.
- Timeout:
  - The counter clears on every accepted byte and on every state entry.
  - It increments each cycle in S_LEN1 and S_DATA with no accepted byte.
  - When it reaches TIMEOUT_CYC-1 with no byte that cycle -> S_ERR.
  - A byte accepted in that same cycle wins; no error.
- reload (any state):
  - Next state is S_LEN0 with cpu_rst=1, done=0, err=0.
  - All counters cleared; mem_addr unchanged.
  - A byte handshaked in the same cycle is discarded.
  - A pending mem_we scheduled for the next cycle is suppressed.
- Overflow is checked on the length only. A word index never exceeds len-1, so mem_addr never wraps.
- rst mid-load immediately returns all outputs to their reset values; partially written memory contents are not cleared.

Test Plan:
- Reset, then send 00 02 | 12 34 56 78 | 9A BC DE F0 back-to-back -> the bench must see:
  - mem_we pulses at addr 0 data 0x12345678 and at addr 1 data 0x9ABCDEF0, with exactly 2 pulses total;
  - cpu_rst=0 and done=1 one cycle after the 2nd pulse;
  - in_ready=0 thereafter.
- Send 00 00 -> no mem_we; cpu_rst falls one cycle after the 2nd byte; done=1.
- With ADDR_W=8, send 01 01 (len 257) -> err=1 and in_ready=0 the cycle after; cpu_rst stays 1; no mem_we.
- TIMEOUT_CYC=16: send 00 01 AA, then idle -> err=1 after 16 idle cycles. A repeat where a byte arrives on idle cycle 15 must give no error.
- Mid-image reload: send 00 03 + 5 data bytes, pulse reload, then send the full image 00 01 11 22 33 44 -> the bench must see:
  - 1 write from the aborted load (addr 0);
  - then addr 0 data 0x11223344;
  - done=1;
  - err clears on reload.
- Assert rst during S_DATA -> all outputs at reset values asynchronously (before the next clk edge); a subsequent full load succeeds.
